// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the instruction-fetch and
// data-access paths of the MIPS core. Round-robin grant (data wins a tie after
// an instruction grant), plus the LL/SC link register. SCs that cannot succeed
// are completed locally in one cycle without touching the RAM.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // instruction side
    input  logic              iren,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    // data side
    input  logic              dren,
    input  logic              dwen,
    input  logic              datomic,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    // RAM side
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DACC   = 2'd1;
    localparam logic [1:0] IACC   = 2'd2;
    localparam logic [1:0] SCFAIL = 2'd3;

    localparam logic GRANT_INSTR = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              link_valid_q, link_valid_d;
    logic [ADDR_W-1:0] link_addr_q, link_addr_d;

    logic dreq;
    logic sc_req;
    logic ll_req;
    logic sc_ok;
    logic link_hit;

    assign dreq     = dren | dwen;
    assign sc_req   = dwen & datomic;
    assign ll_req   = dren & datomic;
    assign link_hit = link_valid_q & (link_addr_q == daddr);
    assign sc_ok    = link_hit;

    // Next-state: arbitration in IDLE, completion / abort handling elsewhere.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        unique case (state_q)
            IDLE: begin
                if (dreq && (last_grant_q == GRANT_INSTR || !iren)) begin
                    state_d = (sc_req && !sc_ok) ? SCFAIL : DACC;
                end else if (iren) begin
                    state_d = IACC;
                end
            end
            DACC: begin
                if (!dreq) begin
                    // Requester withdrew: abandon without touching grant or link.
                    state_d = IDLE;
                end else if (ram_ready) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_DATA;
                    if (ll_req) begin
                        link_valid_d = 1'b1;
                        link_addr_d  = daddr;
                    end
                    if (dwen) begin
                        // Any SC drops the link; a plain SW only if it hits it.
                        if (datomic || link_hit) begin
                            link_valid_d = 1'b0;
                        end
                    end
                end
            end
            IACC: begin
                if (!iren) begin
                    state_d = IDLE;
                end else if (ram_ready) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_INSTR;
                end
            end
            SCFAIL: begin
                state_d      = IDLE;
                last_grant_d = GRANT_DATA;
                link_valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_INSTR;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    // RAM strobes and requester handshakes, decoded from state and ram_ready.
    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = '0;
        dload     = '0;
        unique case (state_q)
            IDLE: begin
            end
            DACC: begin
                ram_ren   = dren;
                ram_wen   = dwen;
                ram_addr  = daddr;
                ram_store = dstore;
                if (ram_ready && dreq) begin
                    dwait = 1'b0;
                    // Only SCs that passed the link check reach DACC.
                    dload = sc_req ? DATA_W'(1) : ram_load;
                end
            end
            IACC: begin
                ram_ren  = iren;
                ram_addr = iaddr;
                if (ram_ready && iren) begin
                    iwait = 1'b0;
                    iload = ram_load;
                end
            end
            SCFAIL: begin
                dwait = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a two-cycle-latency RAM model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          iren;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] iload;
    logic          iwait;
    logic          dren;
    logic          dwen;
    logic          datomic;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic [DW-1:0] dload;
    logic          dwait;
    logic          ram_ren;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_store;
    logic [DW-1:0] ram_load;
    logic          ram_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .iren      (iren),
        .iaddr     (iaddr),
        .iload     (iload),
        .iwait     (iwait),
        .dren      (dren),
        .dwen      (dwen),
        .datomic   (datomic),
        .daddr     (daddr),
        .dstore    (dstore),
        .dload     (dload),
        .dwait     (dwait),
        .ram_ren   (ram_ren),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_store (ram_store),
        .ram_load  (ram_load),
        .ram_ready (ram_ready)
    );

    // RAM model: ram_ready in the second cycle of a strobed access.
    logic [DW-1:0] mem [0:255];
    int unsigned   ram_cnt;
    logic          ready_en;
    logic          strobe;

    assign strobe    = ram_ren | ram_wen;
    assign ram_ready = ready_en && strobe && (ram_cnt == 1);
    assign ram_load  = mem[ram_addr[9:2]];

    always @(posedge clk) begin
        if (rst || !strobe) ram_cnt <= 0;
        else ram_cnt <= ram_cnt + 1;
        if (ram_wen && ram_ready) mem[ram_addr[9:2]] <= ram_store;
    end

    // One data transaction; cyc counts sampled cycles until dwait low (99 on timeout).
    task automatic data_xfer(input logic ren, input logic wen, input logic atomic,
                             input logic [AW-1:0] addr, input logic [DW-1:0] store,
                             output logic [DW-1:0] load, output int cyc,
                             output logic saw_wen, output logic [DW-1:0] wen_store);
        @(negedge clk);
        dren = ren; dwen = wen; datomic = atomic; daddr = addr; dstore = store;
        cyc = 0; saw_wen = 1'b0; wen_store = '0; load = 'x;
        for (int i = 0; i < 20; i++) begin
            #1;
            cyc++;
            if (ram_wen) begin saw_wen = 1'b1; wen_store = ram_store; end
            if (!dwait) begin load = dload; break; end
            @(negedge clk);
        end
        if (dwait) cyc = 99;
        @(posedge clk);
        #1;
        dren = 1'b0; dwen = 1'b0; datomic = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        if ({ram_ren, ram_wen, iwait, dwait} !== 4'b0011) begin
            $display("FAIL reset_strobes: got %b want 0011", {ram_ren, ram_wen, iwait, dwait});
            n_bad++;
        end
        n_cmp++;
        if ({ram_addr, ram_store, iload, dload} !== '0) begin
            $display("FAIL reset_buses: addr %h store %h iload %h dload %h want all 0",
                     ram_addr, ram_store, iload, dload);
            n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_instr_only;
        logic [DW-1:0] ld, st;
        int cyc;
        logic sw;
        data_xfer(1'b0, 1'b1, 1'b0, 32'h40, 32'h8C22_0004, ld, cyc, sw, st);
        data_xfer(1'b0, 1'b1, 1'b0, 32'h120, 32'h11, ld, cyc, sw, st);
        @(negedge clk);
        iren = 1'b1; iaddr = 32'h40;
        #1;
        if (iwait !== 1'b1 || ram_ren !== 1'b0) begin
            $display("FAIL instr_arb_cycle: iwait %b ram_ren %b want 1 0", iwait, ram_ren);
            n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        #1;
        if (ram_ren !== 1'b1 || ram_addr !== 32'h40 || iwait !== 1'b1) begin
            $display("FAIL instr_iacc1: ren %b addr %h iwait %b want 1 40 1",
                     ram_ren, ram_addr, iwait);
            n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        #1;
        if (iwait !== 1'b0 || iload !== 32'h8C22_0004) begin
            $display("FAIL instr_ready: iwait %b iload %h want 0 8c220004", iwait, iload);
            n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        #1;
        if (iwait !== 1'b1) begin
            $display("FAIL instr_one_cycle: iwait %b want 1", iwait);
            n_bad++;
        end
        n_cmp++;
        iren = 1'b0;
    endtask

    task automatic test_simultaneous;
        logic [3:0] seq;
        int g;
        int last;
        @(negedge clk);
        rst = 1'b1;
        iren = 1'b1; iaddr = 32'h40;
        dren = 1'b1; daddr = 32'h40;
        @(negedge clk);
        rst = 1'b0;
        seq = '0; g = 0; last = 0;
        for (int i = 1; i <= 40 && g < 4; i++) begin
            #1;
            if (!dwait) begin seq = {seq[2:0], 1'b1}; g++; last = i; end
            if (!iwait) begin seq = {seq[2:0], 1'b0}; g++; last = i; end
            @(negedge clk);
        end
        iren = 1'b0; dren = 1'b0;
        if (g !== 4 || seq !== 4'b1010) begin
            $display("FAIL sim_order: got %0d grants %b want 4 1010 (D,I,D,I)", g, seq);
            n_bad++;
        end
        n_cmp++;
        if (last !== 12) begin
            $display("FAIL sim_timing: fourth grant at cycle %0d want 12", last);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_ll_sc_success;
        logic [DW-1:0] ld, st;
        int cyc;
        logic sw;
        data_xfer(1'b0, 1'b1, 1'b0, 32'h100, 32'h5, ld, cyc, sw, st);
        data_xfer(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, ld, cyc, sw, st);
        if (ld !== 32'h5 || cyc !== 3) begin
            $display("FAIL ll_load: got %h in %0d want 5 in 3", ld, cyc);
            n_bad++;
        end
        n_cmp++;
        data_xfer(1'b0, 1'b1, 1'b1, 32'h100, 32'h7, ld, cyc, sw, st);
        if (ld !== 32'h1 || cyc !== 3 || sw !== 1'b1 || st !== 32'h7) begin
            $display("FAIL sc_ok: dload %h cyc %0d wen %b store %h want 1 3 1 7", ld, cyc, sw, st);
            n_bad++;
        end
        n_cmp++;
        data_xfer(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, ld, cyc, sw, st);
        if (ld !== 32'h7) begin
            $display("FAIL sc_ok_written: got %h want 7", ld);
            n_bad++;
        end
        n_cmp++;
        data_xfer(1'b0, 1'b1, 1'b1, 32'h100, 32'h8, ld, cyc, sw, st);
        if (ld !== 32'h0 || cyc !== 2 || sw !== 1'b0) begin
            $display("FAIL sc_after_sc: dload %h cyc %0d wen %b want 0 2 0", ld, cyc, sw);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_ll_sc_broken;
        logic [DW-1:0] ld, st;
        int cyc;
        logic sw;
        data_xfer(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, ld, cyc, sw, st);
        data_xfer(1'b0, 1'b1, 1'b0, 32'h100, 32'h9, ld, cyc, sw, st);
        data_xfer(1'b0, 1'b1, 1'b1, 32'h100, 32'h7, ld, cyc, sw, st);
        if (ld !== 32'h0 || cyc !== 2 || sw !== 1'b0) begin
            $display("FAIL sc_broken: dload %h cyc %0d wen %b want 0 2 0", ld, cyc, sw);
            n_bad++;
        end
        n_cmp++;
        data_xfer(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, ld, cyc, sw, st);
        if (ld !== 32'h9) begin
            $display("FAIL sc_broken_mem: got %h want 9", ld);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_sc_wrong_addr;
        logic [DW-1:0] ld, st;
        int cyc;
        logic sw;
        data_xfer(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, ld, cyc, sw, st);
        data_xfer(1'b0, 1'b1, 1'b1, 32'h104, 32'h7, ld, cyc, sw, st);
        if (ld !== 32'h0 || cyc !== 2 || sw !== 1'b0) begin
            $display("FAIL sc_wrong_addr: dload %h cyc %0d wen %b want 0 2 0", ld, cyc, sw);
            n_bad++;
        end
        n_cmp++;
        data_xfer(1'b0, 1'b1, 1'b1, 32'h100, 32'h7, ld, cyc, sw, st);
        if (ld !== 32'h0 || cyc !== 2) begin
            $display("FAIL sc_link_cleared: dload %h cyc %0d want 0 2", ld, cyc);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_link_kept;
        logic [DW-1:0] ld, st;
        int cyc;
        logic sw;
        data_xfer(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, ld, cyc, sw, st);
        data_xfer(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, ld, cyc, sw, st);
        data_xfer(1'b0, 1'b1, 1'b0, 32'h108, 32'h3, ld, cyc, sw, st);
        data_xfer(1'b0, 1'b1, 1'b1, 32'h100, 32'h55, ld, cyc, sw, st);
        if (ld !== 32'h1 || cyc !== 3 || sw !== 1'b1 || st !== 32'h55) begin
            $display("FAIL link_kept: dload %h cyc %0d wen %b store %h want 1 3 1 55",
                     ld, cyc, sw, st);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_abort;
        logic [DW-1:0] ld, st;
        logic [1:0] first;
        int cyc;
        logic sw;
        // Leave last grant on the data side, then abort an instruction fetch.
        data_xfer(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, ld, cyc, sw, st);
        ready_en = 1'b0;
        @(negedge clk);
        iren = 1'b1; iaddr = 32'h40;
        @(negedge clk);
        #1;
        if (ram_ren !== 1'b1) begin
            $display("FAIL abort_iacc: ram_ren %b want 1", ram_ren);
            n_bad++;
        end
        n_cmp++;
        iren = 1'b0;
        #1;
        if (ram_ren !== 1'b0 || iwait !== 1'b1) begin
            $display("FAIL abort_drop: ram_ren %b iwait %b want 0 1", ram_ren, iwait);
            n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        ready_en = 1'b1;
        iren = 1'b1; dren = 1'b1; daddr = 32'h40;
        first = 2'b00;
        for (int i = 0; i < 10 && first == 2'b00; i++) begin
            #1;
            first = {!dwait, !iwait};
            @(negedge clk);
        end
        iren = 1'b0; dren = 1'b0;
        if (first !== 2'b01) begin
            $display("FAIL abort_keeps_grant: first grant {d,i}=%b want 01", first);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid_access;
        logic [DW-1:0] ld, st;
        int cyc;
        logic sw;
        data_xfer(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, ld, cyc, sw, st);
        ready_en = 1'b0;
        @(negedge clk);
        dwen = 1'b1; daddr = 32'h120; dstore = 32'hDEAD;
        @(negedge clk);
        #1;
        if (ram_wen !== 1'b1) begin
            $display("FAIL rst_mid_pre: ram_wen %b want 1", ram_wen);
            n_bad++;
        end
        n_cmp++;
        #1;
        rst = 1'b1;
        #1;
        if (ram_wen !== 1'b0 || ram_addr !== '0 || dwait !== 1'b1) begin
            $display("FAIL rst_mid_async: wen %b addr %h dwait %b want 0 0 1",
                     ram_wen, ram_addr, dwait);
            n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        rst = 1'b0; dwen = 1'b0; ready_en = 1'b1;
        data_xfer(1'b0, 1'b1, 1'b1, 32'h100, 32'h7, ld, cyc, sw, st);
        if (ld !== 32'h0 || cyc !== 2 || sw !== 1'b0) begin
            $display("FAIL rst_mid_sc: dload %h cyc %0d wen %b want 0 2 0", ld, cyc, sw);
            n_bad++;
        end
        n_cmp++;
        data_xfer(1'b1, 1'b0, 1'b0, 32'h120, 32'h0, ld, cyc, sw, st);
        if (ld !== 32'h11) begin
            $display("FAIL rst_mid_discard: got %h want 11", ld);
            n_bad++;
        end
        n_cmp++;
    endtask

    initial begin
        rst = 1'b1; ready_en = 1'b1;
        iren = 1'b0; iaddr = '0;
        dren = 1'b0; dwen = 1'b0; datomic = 1'b0; daddr = '0; dstore = '0;
        test_reset;
        test_instr_only;
        test_simultaneous;
        test_ll_sc_success;
        test_ll_sc_broken;
        test_sc_wrong_addr;
        test_link_kept;
        test_abort;
        test_reset_mid_access;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
